// File: rtl/reg_shift_bank.sv
`default_nettype none
// ==========================================================================
// reg_shift_bank: WIDTH x DEPTH shift bank with ordered pop, indexed read
// and drop/overwrite full policy. Macro REG_SHIFT_BANK_STATS_EN adds counters.
// Revision: 1.0
// ==========================================================================
module reg_shift_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     mode_i,
  input  logic [IDX_W-1:0]         rd_idx_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     pop_valid_o,
  output logic [CNT_W-1:0]         count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [DEPTH*WIDTH-1:0]   data_o,
  output logic [15:0]              push_cnt_o,
  output logic [15:0]              drop_cnt_o
);

  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] ent_q;
  logic [DEPTH-1:0][WIDTH-1:0] ent_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic [WIDTH-1:0]            pop_data_q;
  logic [WIDTH-1:0]            pop_data_d;
  logic                        pop_valid_q;
  logic                        pop_valid_d;
  logic                        drop_q;
  logic                        drop_d;

  logic                        w_full;
  logic                        w_pop_acc;
  logic                        w_push_acc;
  logic                        w_push_drop;
  logic [IDX_W-1:0]            w_oldest_idx;

  assign w_full       = (cnt_q == C_DEPTH);
  assign w_pop_acc    = pop_i && (cnt_q != '0);
  // A simultaneous pop frees the slot, so a full bank still accepts the push.
  assign w_push_acc   = push_i && (!w_full || mode_i || w_pop_acc);
  assign w_push_drop  = push_i && !w_push_acc;
  assign w_oldest_idx = IDX_W'(cnt_q - C_ONE);

  always_comb begin
    ent_d       = ent_q;
    cnt_d       = cnt_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    drop_d      = 1'b0;
    if (clear_i) begin
      ent_d      = '0;
      cnt_d      = '0;
      pop_data_d = '0;
    end else begin
      if (w_pop_acc) begin
        pop_data_d = ent_q[w_oldest_idx];
      end
      if (w_push_acc) begin
        for (int i = 1; i < DEPTH; i++) begin
          ent_d[i] = ent_q[i-1];
        end
        ent_d[0] = data_i;
      end
      if (w_push_acc && !w_pop_acc && !w_full) begin
        cnt_d = cnt_q + C_ONE;
      end else if (w_pop_acc && !w_push_acc) begin
        cnt_d = cnt_q - C_ONE;
      end
      // Everything at or beyond the new count is scrubbed, keeping stale data invisible.
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) >= cnt_d) begin
          ent_d[i] = '0;
        end
      end
      pop_valid_d = w_pop_acc;
      drop_d      = w_push_drop;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ent_q       <= '0;
      cnt_q       <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      ent_q       <= ent_d;
      cnt_q       <= cnt_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign rd_data_o   = (CNT_W'(rd_idx_i) < cnt_q) ? ent_q[rd_idx_i] : '0;
  assign pop_data_o  = pop_data_q;
  assign pop_valid_o = pop_valid_q;
  assign count_o     = cnt_q;
  assign full_o      = w_full;
  assign empty_o     = (cnt_q == '0);
  assign drop_o      = drop_q;
  assign data_o      = ent_q;

`ifdef REG_SHIFT_BANK_STATS_EN
  logic [15:0] push_cnt_q;
  logic [15:0] push_cnt_d;
  logic [15:0] drop_cnt_q;
  logic [15:0] drop_cnt_d;

  always_comb begin
    push_cnt_d = push_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_i) begin
      push_cnt_d = '0;
      drop_cnt_d = '0;
    end else begin
      if (w_push_acc && (push_cnt_q != 16'hFFFF)) push_cnt_d = push_cnt_q + 16'd1;
      if (w_push_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      push_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      push_cnt_q <= push_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign push_cnt_o = push_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`else
  assign push_cnt_o = '0;
  assign drop_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_shift_bank.sv
`default_nettype none
// ==========================================================================
// tb_reg_shift_bank: randomized + directed bench for reg_shift_bank (4 x 32).
// Revision: 1.0
// ==========================================================================
module tb_reg_shift_bank;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 3;

  logic                   clk;
  logic                   rst_i;
  logic                   clear_i;
  logic                   push_i;
  logic [WIDTH-1:0]       data_i;
  logic                   pop_i;
  logic                   mode_i;
  logic [IDX_W-1:0]       rd_idx_i;
  logic [WIDTH-1:0]       rd_data_o;
  logic [WIDTH-1:0]       pop_data_o;
  logic                   pop_valid_o;
  logic [CNT_W-1:0]       count_o;
  logic                   full_o;
  logic                   empty_o;
  logic                   drop_o;
  logic [DEPTH*WIDTH-1:0] data_o;
  logic [15:0]            push_cnt_o;
  logic [15:0]            drop_cnt_o;

  int total = 0;
  int bad   = 0;

  // Reference model: queue index 0 is the newest entry.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_popd = '0;
  bit               m_popv = 0;
  bit               m_drop = 0;
  int               m_pushc = 0;
  int               m_dropc = 0;

  reg_shift_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .push_i(push_i),
    .data_i(data_i), .pop_i(pop_i), .mode_i(mode_i), .rd_idx_i(rd_idx_i),
    .rd_data_o(rd_data_o), .pop_data_o(pop_data_o), .pop_valid_o(pop_valid_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .drop_o(drop_o),
    .data_o(data_o), .push_cnt_o(push_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void model_update(input bit p, input logic [WIDTH-1:0] d,
                                       input bit pp, input bit m, input bit c);
    bit do_pop;
    m_popv = 0;
    m_drop = 0;
    if (c) begin
      mq.delete();
      m_popd  = '0;
      m_pushc = 0;
      m_dropc = 0;
      return;
    end
    do_pop = pp && (mq.size() > 0);
    if (do_pop) m_popd = mq[mq.size()-1];
    if (p) begin
      if (mq.size() == DEPTH && !m && !do_pop) begin
        m_drop = 1;
        if (m_dropc < 65535) m_dropc++;
      end else begin
        mq.push_front(d);
        if (m_pushc < 65535) m_pushc++;
      end
    end
    if (do_pop) void'(mq.pop_back());
    else if (mq.size() > DEPTH) void'(mq.pop_back());
    m_popv = do_pop;
  endfunction

  function automatic logic [DEPTH*WIDTH-1:0] exp_data();
    logic [DEPTH*WIDTH-1:0] r = '0;
    for (int i = 0; i < mq.size(); i++) r[i*WIDTH +: WIDTH] = mq[i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(input int idx);
    return (idx < mq.size()) ? mq[idx] : '0;
  endfunction

  function automatic logic [15:0] exp_pushc();
`ifdef REG_SHIFT_BANK_STATS_EN
    return 16'(m_pushc);
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_dropc();
`ifdef REG_SHIFT_BANK_STATS_EN
    return 16'(m_dropc);
`else
    return 16'd0;
`endif
  endfunction

  task automatic step(input bit p, input logic [WIDTH-1:0] d, input bit pp,
                      input bit m, input bit c);
    @(negedge clk);
    push_i = p; data_i = d; pop_i = pp; mode_i = m; clear_i = c;
    @(posedge clk);
    model_update(p, d, pp, m, c);
    #1;
    push_i = 0; pop_i = 0; clear_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 0;
    #100;
    @(negedge clk);
    rst_i = 1;
    model_update(0, '0, 0, 0, 1);
    #1;
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin bad++; $display("FAIL reset_flags empty=%b full=%b exp empty=1 full=0", empty_o, full_o); end
    total++; if (data_o !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_o); end
    total++; if (pop_valid_o !== 1'b0 || drop_o !== 1'b0 || pop_data_o !== '0) begin bad++; $display("FAIL reset_pulses popv=%b drop=%b popd=%h exp 0", pop_valid_o, drop_o, pop_data_o); end
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx_i = IDX_W'(i);
      #1;
      total++; if (rd_data_o !== '0) begin bad++; $display("FAIL reset_rd idx=%0d got=%h exp=0", i, rd_data_o); end
    end
  endtask

  task automatic test_push_read();
    step(1, 32'h0000F2F2, 0, 0, 0);
    step(1, 32'h0000A1A1, 0, 0, 0);
    step(1, 32'h0000FFFF, 0, 0, 0);
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL push3_count got=%0d exp=3", count_o); end
    total++; if (data_o !== {32'h0, 32'h0000F2F2, 32'h0000A1A1, 32'h0000FFFF}) begin bad++; $display("FAIL push3_data got=%h", data_o); end
    rd_idx_i = 2'd1; #1;
    total++; if (rd_data_o !== 32'h0000A1A1) begin bad++; $display("FAIL rd_idx1 got=%h exp=0000a1a1", rd_data_o); end
    rd_idx_i = 2'd3; #1;
    total++; if (rd_data_o !== 32'h0) begin bad++; $display("FAIL rd_idx3_beyond_count got=%h exp=0", rd_data_o); end
  endtask

  task automatic fill_1_to_4();
    step(0, '0, 0, 0, 1);
    for (int v = 1; v <= 4; v++) step(1, WIDTH'(v), 0, 0, 0);
  endtask

  task automatic test_overflow();
    fill_1_to_4();
    total++; if (full_o !== 1'b1 || count_o !== 3'd4) begin bad++; $display("FAIL fill_full full=%b count=%0d exp 1/4", full_o, count_o); end
    step(1, 32'd5, 0, 0, 0);
    total++; if (drop_o !== 1'b1) begin bad++; $display("FAIL drop_pulse got=%b exp=1", drop_o); end
    total++; if (data_o !== {32'd1, 32'd2, 32'd3, 32'd4}) begin bad++; $display("FAIL drop_data got=%h exp unchanged 4,3,2,1", data_o); end
    step(0, '0, 0, 0, 0);
    total++; if (drop_o !== 1'b0) begin bad++; $display("FAIL drop_pulse_end got=%b exp=0", drop_o); end
    step(1, 32'd5, 0, 1, 0);
    total++; if (data_o !== {32'd2, 32'd3, 32'd4, 32'd5} || count_o !== 3'd4) begin bad++; $display("FAIL overwrite data=%h count=%0d exp 5,4,3,2/4", data_o, count_o); end
    total++; if (drop_o !== 1'b0) begin bad++; $display("FAIL overwrite_nodrop got=%b exp=0", drop_o); end
  endtask

  task automatic test_push_pop_full();
    fill_1_to_4();
    step(1, 32'd9, 1, 0, 0);
    total++; if (pop_valid_o !== 1'b1 || pop_data_o !== 32'd1) begin bad++; $display("FAIL pushpop_full popv=%b popd=%h exp 1/1", pop_valid_o, pop_data_o); end
    total++; if (data_o !== {32'd2, 32'd3, 32'd4, 32'd9} || count_o !== 3'd4) begin bad++; $display("FAIL pushpop_full_data data=%h count=%0d", data_o, count_o); end
    step(0, '0, 1, 0, 0);
    total++; if (pop_data_o !== 32'd2 || count_o !== 3'd3 || data_o !== {32'd0, 32'd3, 32'd4, 32'd9}) begin bad++; $display("FAIL pop_only popd=%h count=%0d data=%h", pop_data_o, count_o, data_o); end
    step(0, '0, 0, 0, 0);
    total++; if (pop_valid_o !== 1'b0) begin bad++; $display("FAIL pop_pulse_end got=%b exp=0", pop_valid_o); end
  endtask

  task automatic test_empty_edge();
    step(0, '0, 0, 0, 1);
    step(1, 32'h000000AB, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    total++; if (pop_valid_o !== 1'b0 || pop_data_o !== 32'h000000AB) begin bad++; $display("FAIL pop_empty popv=%b popd=%h exp 0/ab", pop_valid_o, pop_data_o); end
    step(1, 32'd7, 1, 0, 0);
    total++; if (count_o !== 3'd1 || data_o !== {96'h0, 32'd7} || pop_valid_o !== 1'b0) begin bad++; $display("FAIL pushpop_empty count=%0d data=%h popv=%b", count_o, data_o, pop_valid_o); end
  endtask

  task automatic test_stats();
    fill_1_to_4();
    step(1, 32'd5, 0, 0, 0);
    total++; if (push_cnt_o !== exp_pushc() || drop_cnt_o !== exp_dropc()) begin bad++; $display("FAIL stats push=%0d drop=%0d exp %0d/%0d", push_cnt_o, drop_cnt_o, exp_pushc(), exp_dropc()); end
    step(0, '0, 0, 0, 1);
    total++; if (push_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0) begin bad++; $display("FAIL stats_clear push=%0d drop=%0d exp 0/0", push_cnt_o, drop_cnt_o); end
  endtask

  task automatic test_random();
    bit p, pp, m, c;
    logic [WIDTH-1:0] d;
    for (int n = 0; n < 300; n++) begin
      p  = ($urandom_range(0, 99) < 60);
      pp = ($urandom_range(0, 99) < 35);
      m  = $urandom_range(0, 1) == 1;
      c  = ($urandom_range(0, 99) < 3);
      d  = $urandom;
      step(p, d, pp, m, c);
      rd_idx_i = IDX_W'($urandom_range(0, DEPTH-1));
      #1;
      total++; if (count_o !== CNT_W'(mq.size())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count_o, mq.size()); end
      total++; if (data_o !== exp_data()) begin bad++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, data_o, exp_data()); end
      total++; if (full_o !== (mq.size() == DEPTH) || empty_o !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_flags n=%0d full=%b empty=%b size=%0d", n, full_o, empty_o, mq.size()); end
      total++; if (pop_valid_o !== m_popv || pop_data_o !== m_popd) begin bad++; $display("FAIL rnd_pop n=%0d popv=%b popd=%h exp %b/%h", n, pop_valid_o, pop_data_o, m_popv, m_popd); end
      total++; if (drop_o !== m_drop) begin bad++; $display("FAIL rnd_drop n=%0d got=%b exp=%b", n, drop_o, m_drop); end
      total++; if (rd_data_o !== exp_rd(int'(rd_idx_i))) begin bad++; $display("FAIL rnd_rd n=%0d idx=%0d got=%h exp=%h", n, rd_idx_i, rd_data_o, exp_rd(int'(rd_idx_i))); end
      total++; if (push_cnt_o !== exp_pushc() || drop_cnt_o !== exp_dropc()) begin bad++; $display("FAIL rnd_stats n=%0d push=%0d drop=%0d exp %0d/%0d", n, push_cnt_o, drop_cnt_o, exp_pushc(), exp_dropc()); end
    end
  endtask

  task automatic test_async_reset();
    step(0, '0, 0, 0, 1);
    step(1, 32'h11, 0, 0, 0);
    step(1, 32'h22, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    total++; if (pop_valid_o !== 1'b1 || pop_data_o !== 32'h11) begin bad++; $display("FAIL pre_areset popv=%b popd=%h exp 1/11", pop_valid_o, pop_data_o); end
    #1;
    rst_i = 0;
    model_update(0, '0, 0, 0, 1);
    #1;
    total++; if (pop_valid_o !== 1'b0 || pop_data_o !== '0 || drop_o !== 1'b0) begin bad++; $display("FAIL areset_pulses popv=%b popd=%h drop=%b exp 0", pop_valid_o, pop_data_o, drop_o); end
    total++; if (count_o !== 3'd0 || data_o !== '0 || empty_o !== 1'b1) begin bad++; $display("FAIL areset_state count=%0d data=%h empty=%b", count_o, data_o, empty_o); end
    total++; if (push_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0) begin bad++; $display("FAIL areset_stats push=%0d drop=%0d exp 0", push_cnt_o, drop_cnt_o); end
    @(negedge clk);
    rst_i = 1;
  endtask

  initial begin
    rst_i = 0; clear_i = 0; push_i = 0; pop_i = 0; mode_i = 0;
    data_i = '0; rd_idx_i = '0;
    test_reset();
    test_push_read();
    test_overflow();
    test_push_pop_full();
    test_empty_edge();
    test_stats();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
